gpio_in_filter: RTL

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/gpio_in_filter.sv | 71 +++++++
 1 files changed

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop synchronizer, per-pin debounce filter,
// and per-pin edge-triggered interrupt pending flags with a combined IRQ.
module gpio_in_filter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] PAD_I,
    input  logic [WIDTH-1:0] FLT_EN,
    input  logic [CNT_W-1:0] FLT_LEN,
    input  logic [WIDTH-1:0] IRQ_RISE_EN,
    input  logic [WIDTH-1:0] IRQ_FALL_EN,
    input  logic [WIDTH-1:0] IRQ_CLR,
    output logic [WIDTH-1:0] GPIO_DI,
    output logic [WIDTH-1:0] IRQ_PEND,
    output logic             IRQ
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] st;
    logic [WIDTH-1:0] st_d;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_comb begin
        rise = st & ~st_d;
        fall = ~st & st_d;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1   <= '0;
            s2   <= '0;
            st   <= '0;
            st_d <= '0;
            pend <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= PAD_I;
            s2   <= s1;
            st_d <= st;
            // set terms are ORed after the clear mask so a coincident set wins
            pend <= (pend & ~IRQ_CLR) | (rise & IRQ_RISE_EN) | (fall & IRQ_FALL_EN);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!FLT_EN[i]) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= FLT_LEN) begin
                    // >= lets a lowered FLT_LEN accept a count already past it
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign GPIO_DI  = st;
    assign IRQ_PEND = pend;
    assign IRQ      = |pend;

endmodule
